// File: rtl/led_blink_pkg.sv
// Shared definitions for the multi-channel LED blinker.
//   MODE_*          : 2-bit per-channel mode encodings driven on i_Mode
//   burst_state_e   : burst pattern state machine states
package led_blink_pkg;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_BURST = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StFlashOn,
      StFlashOff,
      StGap
   } burst_state_e;

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: registered mode, tick counter, burst state machine and LED register.
// Ports:
//   i_Clock       : clock, rising edge
//   i_Reset       : synchronous active-high reset
//   i_Tick        : one-clock timebase pulse shared by all channels
//   i_Mode        : requested mode (MODE_OFF/ON/BLINK/BURST)
//   i_Half_Period : half-period in ticks, 0 treated as 1
//   o_LED         : registered LED drive
module led_blink_channel
   import led_blink_pkg::*;
#(
   parameter int unsigned PER_W   = 12,
   parameter int unsigned BURST_N = 3,
   parameter int unsigned GAP_HP  = 4
) (
   input  logic             i_Clock,
   input  logic             i_Reset,
   input  logic             i_Tick,
   input  logic [1:0]       i_Mode,
   input  logic [PER_W-1:0] i_Half_Period,
   output logic             o_LED
);

   // Four spare bits so GAP_HP * H (GAP_HP <= 15) always fits.
   localparam int unsigned CW = PER_W + 4;

   logic [1:0]    mode_q, mode_d;
   logic [CW-1:0] cnt_q, cnt_d;
   burst_state_e  state_q, state_d;
   logic [3:0]    flash_q, flash_d;
   logic          led_q, led_d;
   logic          mode_chg;
   logic          blink_tgl;

   logic [CW-1:0] half_eff;
   logic [CW-1:0] half_m1;
   logic [CW-1:0] gap_m1;

   // Half-period is used live, so a shorter H takes effect mid-count via ">=".
   assign half_eff = (i_Half_Period == '0) ? CW'(1) : CW'(i_Half_Period);
   assign half_m1  = half_eff - CW'(1);
   assign gap_m1   = CW'(GAP_HP) * half_eff - CW'(1);

   // State register
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         mode_q  <= MODE_OFF;
         cnt_q   <= '0;
         state_q <= StIdle;
         flash_q <= '0;
         led_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         flash_q <= flash_d;
         led_q   <= led_d;
      end
   end

   // Next-state logic; a mode change wins over a coincident tick.
   always_comb begin
      mode_chg  = (i_Mode != mode_q);
      mode_d    = i_Mode;
      cnt_d     = cnt_q;
      state_d   = state_q;
      flash_d   = flash_q;
      blink_tgl = 1'b0;
      if (mode_chg) begin
         cnt_d   = '0;
         state_d = StIdle;
         flash_d = '0;
      end else begin
         unique case (mode_q)
            MODE_BLINK: begin
               if (i_Tick) begin
                  if (cnt_q >= half_m1) begin
                     blink_tgl = 1'b1;
                     cnt_d     = '0;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            MODE_BURST: begin
               unique case (state_q)
                  StIdle: begin
                     state_d = StFlashOn;
                     flash_d = 4'd1;
                     cnt_d   = '0;
                  end
                  StFlashOn: begin
                     if (i_Tick) begin
                        if (cnt_q >= half_m1) begin
                           state_d = StFlashOff;
                           cnt_d   = '0;
                        end else begin
                           cnt_d = cnt_q + CW'(1);
                        end
                     end
                  end
                  StFlashOff: begin
                     if (i_Tick) begin
                        if (cnt_q >= half_m1) begin
                           cnt_d = '0;
                           if (flash_q < 4'(BURST_N)) begin
                              state_d = StFlashOn;
                              flash_d = flash_q + 4'd1;
                           end else begin
                              state_d = StGap;
                           end
                        end else begin
                           cnt_d = cnt_q + CW'(1);
                        end
                     end
                  end
                  StGap: begin
                     if (i_Tick) begin
                        if (cnt_q >= gap_m1) begin
                           state_d = StFlashOn;
                           flash_d = 4'd1;
                           cnt_d   = '0;
                        end else begin
                           cnt_d = cnt_q + CW'(1);
                        end
                     end
                  end
                  default: state_d = StIdle;
               endcase
            end
            default: begin
               // OFF and ON keep the counter parked at zero.
               cnt_d   = '0;
               state_d = StIdle;
               flash_d = '0;
            end
         endcase
      end
   end

   // Output logic: next LED value derived from the next mode/state.
   always_comb begin
      led_d = 1'b0;
      unique case (mode_d)
         MODE_OFF:   led_d = 1'b0;
         MODE_ON:    led_d = 1'b1;
         MODE_BLINK: led_d = mode_chg ? 1'b0 : (led_q ^ blink_tgl);
         default:    led_d = (state_d == StFlashOn);
      endcase
   end

   assign o_LED = led_q;

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: a shared prescaler produces the timebase tick and NUM_CH
// independent channels each drive one LED as OFF, ON, BLINK or BURST.
// Ports:
//   i_Clock       : clock, rising edge
//   i_Reset       : synchronous active-high reset
//   i_Mode        : 2 bits per channel, channel k in [2k+1:2k]
//   i_Half_Period : PER_W bits per channel, channel k in [PER_W*k +: PER_W]
//   o_LED         : registered LED drive, bit k per channel
//   o_Tick        : registered one-clock pulse per timebase tick
module led_blink_multi
   import led_blink_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 25000000,
   parameter int unsigned TICK_HZ = 1000,
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned PER_W   = 12,
   parameter int unsigned BURST_N = 3,
   parameter int unsigned GAP_HP  = 4
) (
   input  logic                    i_Clock,
   input  logic                    i_Reset,
   input  logic [2*NUM_CH-1:0]     i_Mode,
   input  logic [PER_W*NUM_CH-1:0] i_Half_Period,
   output logic [NUM_CH-1:0]       o_LED,
   output logic                    o_Tick
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0] pre_q;
   logic          tick_q;

   // Prescaler: the tick is registered in the wrap clock, so the first pulse
   // lands DIV clocks after reset release.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else if (pre_q == PW'(DIV - 1)) begin
         pre_q  <= '0;
         tick_q <= 1'b1;
      end else begin
         pre_q  <= pre_q + PW'(1);
         tick_q <= 1'b0;
      end
   end

   assign o_Tick = tick_q;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      led_blink_channel #(
         .PER_W   (PER_W),
         .BURST_N (BURST_N),
         .GAP_HP  (GAP_HP)
      ) u_ch (
         .i_Clock       (i_Clock),
         .i_Reset       (i_Reset),
         .i_Tick        (tick_q),
         .i_Mode        (i_Mode[2*k +: 2]),
         .i_Half_Period (i_Half_Period[PER_W*k +: PER_W]),
         .o_LED         (o_LED[k])
      );
   end

endmodule
